// File: rtl/uart_mmio_if.sv
// CPU data-memory bus bundle seen by the UART register block.
// The CPU drives address, strobes and write data; the block returns read data.
interface uart_mmio_if;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, MemRead, MemWrite, wdata, input rdata);
    modport slave  (input addr, MemRead, MemWrite, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_regs.sv
// Memory-mapped UART front end: TX FIFO paced into the sender, RX FIFO from the
// receiver, control/status register with sticky flags and a registered interrupt.
module uart_mmio_regs #(
    parameter logic [31:0] TXD_ADDR   = 32'h4000_0018,
    parameter logic [31:0] RXD_ADDR   = 32'h4000_001C,
    parameter logic [31:0] CON_ADDR   = 32'h4000_0020,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    uart_mmio_if.slave  bus,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    logic [7:0]       tx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [CNT_W-1:0] tx_count_r;
    logic [7:0]       rx_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CNT_W-1:0] rx_count_r;

    logic [1:0] state_r;
    logic [7:0] tx_data_r;
    logic       tx_start_r;
    logic       irq_r;
    logic       tx_ie_r, rx_ie_r, tx_done_r, rx_overrun_r, tx_drop_r;

    logic sel_txd_s, sel_rxd_s, sel_con_s, con_rd_s;
    logic tx_full_s, tx_push_s, tx_pop_s, tx_drop_set_s, tx_done_set_s;
    logic rx_full_s, rx_avail_s, rx_push_s, rx_pop_s, rx_overrun_set_s;
    logic [6:0] con_bits_s;
    logic [23:0] wdata_unused_s;

    // Address decode, FIFO handshakes and sticky-flag set events.
    always_comb begin
        sel_txd_s        = (bus.addr == TXD_ADDR);
        sel_rxd_s        = (bus.addr == RXD_ADDR);
        sel_con_s        = (bus.addr == CON_ADDR);
        con_rd_s         = bus.MemRead & sel_con_s;
        tx_full_s        = (tx_count_r == CNT_W'(FIFO_DEPTH));
        tx_push_s        = bus.MemWrite & sel_txd_s & ~tx_full_s;
        tx_drop_set_s    = bus.MemWrite & sel_txd_s & tx_full_s;
        tx_pop_s         = (state_r == ST_START);
        tx_done_set_s    = (state_r == ST_WAIT_LO) & ~tx_busy;
        rx_full_s        = (rx_count_r == CNT_W'(FIFO_DEPTH));
        rx_avail_s       = (rx_count_r != {CNT_W{1'b0}});
        rx_pop_s         = bus.MemRead & sel_rxd_s & rx_avail_s;
        rx_push_s        = rx_valid & (~rx_full_s | rx_pop_s);
        rx_overrun_set_s = rx_valid & rx_full_s & ~rx_pop_s;
        con_bits_s       = {tx_drop_r, rx_overrun_r, tx_full_s, rx_avail_s,
                            tx_done_r, rx_ie_r, tx_ie_r};
        wdata_unused_s   = bus.wdata[31:8];
    end

    // Combinational read mux; only an RXD read of a non-empty FIFO returns data.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.MemRead && sel_con_s) begin
            bus.rdata = {25'd0, con_bits_s};
        end else if (rx_pop_s) begin
            bus.rdata = {24'd0, rx_mem_r[rx_rd_ptr_r]};
        end else begin
            bus.rdata = 32'd0;
        end
    end

    // TX FIFO storage; stale entries are harmless because pointers gate access.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= bus.wdata[7:0];
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    end

    // FIFO pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_r <= {PTR_W{1'b0}};
            tx_rd_ptr_r <= {PTR_W{1'b0}};
            tx_count_r  <= {CNT_W{1'b0}};
            rx_wr_ptr_r <= {PTR_W{1'b0}};
            rx_rd_ptr_r <= {PTR_W{1'b0}};
            rx_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_W'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_W'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_W'(1);
                2'b01:   tx_count_r <= tx_count_r - CNT_W'(1);
                default: tx_count_r <= tx_count_r;
            endcase
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_W'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_W'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_W'(1);
                2'b01:   rx_count_r <= rx_count_r - CNT_W'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sender pacing FSM; tx_start and tx_data are loaded on entry to START.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'd0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_count_r != {CNT_W{1'b0}}) begin
                        state_r    <= ST_START;
                        tx_start_r <= 1'b1;
                        tx_data_r  <= tx_mem_r[tx_rd_ptr_r];
                    end
                end
                ST_START:   state_r <= ST_WAIT_HI;
                ST_WAIT_HI: if (tx_busy)  state_r <= ST_WAIT_LO;
                ST_WAIT_LO: if (!tx_busy) state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Control bits, sticky flags (a set in the same cycle as a CON read wins) and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ie_r      <= 1'b0;
            rx_ie_r      <= 1'b0;
            tx_done_r    <= 1'b0;
            rx_overrun_r <= 1'b0;
            tx_drop_r    <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            if (bus.MemWrite && sel_con_s) begin
                tx_ie_r <= bus.wdata[0];
                rx_ie_r <= bus.wdata[1];
            end
            tx_done_r    <= tx_done_set_s    | (tx_done_r    & ~con_rd_s);
            rx_overrun_r <= rx_overrun_set_s | (rx_overrun_r & ~con_rd_s);
            tx_drop_r    <= tx_drop_set_s    | (tx_drop_r    & ~con_rd_s);
            irq_r        <= (tx_ie_r & tx_done_r) | (rx_ie_r & rx_avail_s);
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign irq      = irq_r;
endmodule

// File: tb/tb_uart_mmio_regs.sv
// Directed self-checking bench for uart_mmio_regs with a simple sender model
// that stays busy for ten cycles after each start pulse.
module tb_uart_mmio_regs;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       irq;
    int         busy_cnt = 0;
    logic [7:0] sent_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [31:0] rv;

    uart_mmio_if bus_if ();

    uart_mmio_regs dut (
        .clk(clk), .reset(reset), .bus(bus_if.slave),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // Sender model: busy for ten cycles after each start pulse; log launched bytes.
    always @(posedge clk) begin
        if (tx_start) begin
            busy_cnt <= 10;
            sent_q.push_back(tx_data);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr = a; bus_if.wdata = d; bus_if.MemWrite = 1'b1;
        tick();
        bus_if.MemWrite = 1'b0; bus_if.addr = 32'd0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr = a; bus_if.MemRead = 1'b1;
        #2;
        d = bus_if.rdata;
        tick();
        bus_if.MemRead = 1'b0; bus_if.addr = 32'd0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
        bus_if.addr = 32'd0; bus_if.wdata = 32'd0;
        bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        bus_rd(CON, rv);       check("reset_con", rv, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_start", {31'd0, tx_start}, 32'h0);
        check("reset_txdata", {24'd0, tx_data}, 32'h0);

        // single byte with start latency
        bus_wr(TXD, 32'hFFFF_FF41);
        check("lat_early", {31'd0, tx_start}, 32'h0);
        tick();
        check("lat_start", {31'd0, tx_start}, 32'h1);
        check("lat_data", {24'd0, tx_data}, 32'h41);
        tick();
        check("start_pulse", {31'd0, tx_start}, 32'h0);
        repeat (20) tick();
        check("one_sent", sent_q.size(), 32'd1);
        bus_rd(CON, rv);       check("done_set", rv, 32'h04);
        bus_rd(CON, rv);       check("done_clr", rv, 32'h00);

        // five bytes queued behind a busy sender, sixth dropped
        sent_q.delete();
        for (int i = 1; i <= 6; i++) bus_wr(TXD, 32'(i));
        bus_rd(CON, rv);       check("full_drop", rv, 32'h50);
        for (int i = 0; i < 200 && sent_q.size() < 5; i++) tick();
        repeat (20) tick();
        check("burst_count", sent_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < sent_q.size(); i++)
            check("burst_order", {24'd0, sent_q[i]}, 32'(i + 1));
        bus_rd(CON, rv);       check("burst_done", rv, 32'h04);

        // RX overrun
        for (int i = 0; i < 5; i++) rx_push(8'hA0 + 8'(i));
        bus_rd(CON, rv);       check("overrun", rv, 32'h28);
        for (int i = 0; i < 4; i++) begin
            bus_rd(RXD, rv);   check("rx_order", rv, 32'hA0 + 32'(i));
        end
        bus_rd(RXD, rv);       check("rx_empty", rv, 32'h0);
        bus_rd(CON, rv);       check("rx_con_clr", rv, 32'h0);

        // simultaneous pop and push on a full RX FIFO
        for (int i = 0; i < 4; i++) rx_push(8'hC0 + 8'(i));
        bus_if.addr = RXD; bus_if.MemRead = 1'b1; rx_data = 8'hB0; rx_valid = 1'b1;
        #2;
        check("popush_head", bus_if.rdata, 32'hC0);
        tick();
        bus_if.MemRead = 1'b0; rx_valid = 1'b0; bus_if.addr = 32'd0;
        bus_rd(CON, rv);       check("popush_con", rv, 32'h08);
        for (int i = 0; i < 3; i++) begin
            bus_rd(RXD, rv);   check("popush_old", rv, 32'hC1 + 32'(i));
        end
        bus_rd(RXD, rv);       check("popush_new", rv, 32'hB0);

        // RX interrupt timing
        bus_wr(CON, 32'h2);
        rx_push(8'hD5);
        check("irq_rx_n", {31'd0, irq}, 32'h0);
        tick();
        check("irq_rx_n1", {31'd0, irq}, 32'h1);
        bus_rd(RXD, rv);       check("irq_rx_data", rv, 32'hD5);
        check("irq_rx_hold", {31'd0, irq}, 32'h1);
        tick();
        check("irq_rx_drop", {31'd0, irq}, 32'h0);

        // TX-done interrupt
        bus_wr(CON, 32'h1);
        bus_wr(TXD, 32'h5A);
        repeat (25) tick();
        check("irq_tx", {31'd0, irq}, 32'h1);
        bus_rd(CON, rv);       check("irq_tx_con", rv, 32'h05);
        tick();
        check("irq_tx_drop", {31'd0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
